// File: rtl/regfile_writeback_ctrl.sv
// Write-side controller for the 32x32 register file: arbitrates ALU/load results into a FIFO,
// drains one entry per cycle onto the write port and tracks pending destinations in a scoreboard.
module regfile_writeback_ctrl #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_rd,
    input  logic [XLEN-1:0]          mem_data,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_rd,
    output logic [31:0]              busy,
    output logic                     err_waw,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     RegWrite,
    output logic                     flag,
    output logic [4:0]               Write_Reg_Num,
    output logic [XLEN-1:0]          WriteData
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t        fifo [DEPTH];
    entry_t        push_entry;
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          mem_fire;
    logic          alu_fire;
    logic          push;
    logic          pop;
    logic          waw;
    logic [31:0]   busy_next;

    assign full      = (count == FULL_COUNT);
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;
    assign mem_fire  = mem_valid && mem_ready;
    assign alu_fire  = alu_valid && alu_ready;
    assign pop       = (count != '0);
    assign head      = fifo[rd_ptr];
    assign waw       = issue_valid && (issue_rd != 5'd0) && busy[issue_rd];

    // Loads win arbitration; writes to r0 finish the handshake but never occupy a slot.
    always_comb begin
        push_entry = '0;
        push       = 1'b0;
        if (mem_fire) begin
            push_entry = '{rd: mem_rd, data: mem_data};
            push       = (mem_rd != 5'd0);
        end else if (alu_fire) begin
            push_entry = '{rd: alu_rd, data: alu_data};
            push       = (alu_rd != 5'd0);
        end
    end

    // The clear from a retiring write is applied first so a same-edge reissue keeps the bit set.
    always_comb begin
        busy_next = busy;
        if (pop) begin
            busy_next[head.rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            busy          <= '0;
            err_waw       <= 1'b0;
            RegWrite      <= 1'b0;
            flag          <= 1'b0;
            Write_Reg_Num <= '0;
            WriteData     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                RegWrite      <= 1'b1;
                flag          <= 1'b1;
                Write_Reg_Num <= head.rd;
                WriteData     <= head.data;
            end else begin
                RegWrite <= 1'b0;
                flag     <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            busy <= busy_next;
            if (waw) begin
                err_waw <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Self-checking bench for regfile_writeback_ctrl: directed vector table, hand-written corner
// sequences, then randomized traffic compared against a queue-based reference model.
module tb_regfile_writeback_ctrl;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [31:0]     busy;
    logic            err_waw;
    logic [2:0]      count;
    logic            RegWrite;
    logic            flag;
    logic [4:0]      Write_Reg_Num;
    logic [XLEN-1:0] WriteData;

    int total = 0;
    int bad   = 0;

    regfile_writeback_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy(busy), .err_waw(err_waw), .count(count),
        .RegWrite(RegWrite), .flag(flag), .Write_Reg_Num(Write_Reg_Num), .WriteData(WriteData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;  logic [4:0] ard; logic [31:0] adata;
        logic        mv;  logic [4:0] mrd; logic [31:0] mdata;
        logic        iv;  logic [4:0] ird;
        logic        e_ar; logic e_mr;
        logic        e_rw; logic [4:0] e_wrn; logic [31:0] e_wd;
        int          e_cnt; logic [31:0] e_busy; logic e_err;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_busy;
    logic        m_err;
    logic        m_rw;
    logic [4:0]  m_wrn;
    logic [31:0] m_wd;
    logic        m_ar;
    logic        m_mr;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                 input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                                 input logic iv, input logic [4:0] ird);
        alu_valid = av;  alu_rd = ard; alu_data = adata;
        mem_valid = mv;  mem_rd = mrd; mem_data = mdata;
        issue_valid = iv; issue_rd = ird;
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy = '0; m_err = 0; m_rw = 0; m_wrn = 0; m_wd = 0;
    endtask

    // One clock edge of the reference model, driven by the current input values.
    task automatic model_step();
        logic [31:0] old_busy;
        logic        full;
        ent_t        e;
        full     = (mq.size() == DEPTH);
        m_mr     = !full;
        m_ar     = !full && !mem_valid;
        old_busy = m_busy;
        if (mq.size() > 0) begin
            e = mq.pop_front();
            m_rw = 1; m_wrn = e.rd; m_wd = e.data;
            m_busy[e.rd] = 1'b0;
        end else begin
            m_rw = 0;
        end
        if (issue_valid && issue_rd != 0) begin
            if (old_busy[issue_rd]) m_err = 1;
            m_busy[issue_rd] = 1'b1;
        end
        if (mem_valid && m_mr) begin
            if (mem_rd != 0) mq.push_back('{rd: mem_rd, data: mem_data});
        end else if (alu_valid && m_ar) begin
            if (alu_rd != 0) mq.push_back('{rd: alu_rd, data: alu_data});
        end
    endtask

    task automatic do_reset();
        reset = 1;
        idle();
        tick();
        checkOutput("reset_count", 64'(count), 0);
        checkOutput("reset_regwrite", 64'(RegWrite), 0);
        checkOutput("reset_busy", 64'(busy), 0);
        checkOutput("reset_err", 64'(err_waw), 0);
        checkOutput("reset_wrn", 64'(Write_Reg_Num), 0);
        checkOutput("reset_wd", 64'(WriteData), 0);
        reset = 0;
        model_reset();
    endtask

    vec_t vecs[14];

    initial begin
        logic        a_pend, m_pend;
        logic [4:0]  a_rd, r_mrd;
        logic [31:0] a_data, r_mdata;
        logic        r_iv;
        logic [4:0]  r_ird;

        vecs[0]  = '{1, 5, 32'hA,  0, 0, 0,     0, 0, 1, 1, 0, 0, 0,      1, 0,     0};
        vecs[1]  = '{0, 0, 0,      0, 0, 0,     0, 0, 1, 1, 1, 5, 32'hA,  0, 0,     0};
        vecs[2]  = '{0, 0, 0,      0, 0, 0,     0, 0, 1, 1, 0, 5, 32'hA,  0, 0,     0};
        vecs[3]  = '{1, 4, 32'h22, 1, 3, 32'h11,0, 0, 0, 1, 0, 5, 32'hA,  1, 0,     0};
        vecs[4]  = '{1, 4, 32'h22, 0, 0, 0,     0, 0, 1, 1, 1, 3, 32'h11, 1, 0,     0};
        vecs[5]  = '{0, 0, 0,      0, 0, 0,     0, 0, 1, 1, 1, 4, 32'h22, 0, 0,     0};
        vecs[6]  = '{1, 0, 32'hFF, 0, 0, 0,     0, 0, 1, 1, 0, 4, 32'h22, 0, 0,     0};
        vecs[7]  = '{0, 0, 0,      0, 0, 0,     0, 0, 1, 1, 0, 4, 32'h22, 0, 0,     0};
        vecs[8]  = '{0, 0, 0,      0, 0, 0,     1, 7, 1, 1, 0, 4, 32'h22, 0, 32'h80, 0};
        vecs[9]  = '{1, 7, 32'h77, 0, 0, 0,     0, 0, 1, 1, 0, 4, 32'h22, 1, 32'h80, 0};
        vecs[10] = '{0, 0, 0,      0, 0, 0,     0, 0, 1, 1, 1, 7, 32'h77, 0, 0,     0};
        vecs[11] = '{0, 0, 0,      0, 0, 0,     1, 7, 1, 1, 0, 7, 32'h77, 0, 32'h80, 0};
        vecs[12] = '{1, 7, 32'h78, 0, 0, 0,     0, 0, 1, 1, 0, 7, 32'h77, 1, 32'h80, 0};
        vecs[13] = '{0, 0, 0,      0, 0, 0,     1, 7, 1, 1, 1, 7, 32'h78, 0, 32'h80, 1};

        $display("[TB] start");
        reset = 1;
        idle();
        tick();
        do_reset();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].av, vecs[i].ard, vecs[i].adata, vecs[i].mv, vecs[i].mrd,
                          vecs[i].mdata, vecs[i].iv, vecs[i].ird);
            checkOutput($sformatf("vec%0d_alu_ready", i), 64'(alu_ready), 64'(vecs[i].e_ar));
            checkOutput($sformatf("vec%0d_mem_ready", i), 64'(mem_ready), 64'(vecs[i].e_mr));
            tick();
            checkOutput($sformatf("vec%0d_regwrite", i), 64'(RegWrite), 64'(vecs[i].e_rw));
            checkOutput($sformatf("vec%0d_flag", i), 64'(flag), 64'(vecs[i].e_rw));
            checkOutput($sformatf("vec%0d_wrn", i), 64'(Write_Reg_Num), 64'(vecs[i].e_wrn));
            checkOutput($sformatf("vec%0d_wd", i), 64'(WriteData), 64'(vecs[i].e_wd));
            checkOutput($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
            checkOutput($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
            checkOutput($sformatf("vec%0d_err", i), 64'(err_waw), 64'(vecs[i].e_err));
        end

        // Five back-to-back ALU results come out in order, one per cycle.
        do_reset();
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) applyStimulus(1, 5'(i + 1), 32'h100 + 32'(i), 0, 0, 0, 0, 0);
            else idle();
            checkOutput($sformatf("b2b%0d_alu_ready", i), 64'(alu_ready), 1);
            tick();
            checkOutput($sformatf("b2b%0d_regwrite", i), 64'(RegWrite), (i == 0) ? 0 : 1);
            if (i > 0) begin
                checkOutput($sformatf("b2b%0d_wrn", i), 64'(Write_Reg_Num), 64'(i));
                checkOutput($sformatf("b2b%0d_wd", i), 64'(WriteData), 64'h100 + 64'(i - 1) + 1 - 1 + 0);
            end
        end
        idle();
        tick();
        checkOutput("b2b_tail_regwrite", 64'(RegWrite), 0);
        checkOutput("b2b_tail_count", 64'(count), 0);

        // Reset in the middle of traffic discards everything in flight.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
        tick();
        applyStimulus(1, 9, 32'h99, 0, 0, 0, 1, 10);
        tick();
        checkOutput("midreset_pre_count", 64'(count), 1);
        reset = 1;
        applyStimulus(1, 10, 32'hAA, 0, 0, 0, 0, 0);
        tick();
        checkOutput("midreset_count", 64'(count), 0);
        checkOutput("midreset_regwrite", 64'(RegWrite), 0);
        checkOutput("midreset_busy", 64'(busy), 0);
        checkOutput("midreset_wrn", 64'(Write_Reg_Num), 0);
        reset = 0;
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("postreset%0d_regwrite", i), 64'(RegWrite), 0);
        end

        // Randomized traffic against the reference model; producers hold requests until accepted.
        do_reset();
        a_pend = 0; m_pend = 0;
        a_rd = 0; a_data = 0; r_mrd = 0; r_mdata = 0;
        for (int c = 0; c < 600; c++) begin
            if (!a_pend && $urandom_range(0, 1) == 1) begin
                a_pend = 1;
                a_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                a_data = $urandom;
            end
            if (!m_pend && $urandom_range(0, 3) == 0) begin
                m_pend  = 1;
                r_mrd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                r_mdata = $urandom;
            end
            r_iv  = ($urandom_range(0, 2) == 0);
            r_ird = 5'($urandom_range(0, 31));
            applyStimulus(a_pend, a_rd, a_data, m_pend, r_mrd, r_mdata, r_iv, r_ird);
            model_step();
            checkOutput("rnd_alu_ready", 64'(alu_ready), 64'(m_ar));
            checkOutput("rnd_mem_ready", 64'(mem_ready), 64'(m_mr));
            if (m_pend && m_mr) m_pend = 0;
            else if (a_pend && m_ar) a_pend = 0;
            tick();
            checkOutput("rnd_regwrite", 64'(RegWrite), 64'(m_rw));
            checkOutput("rnd_flag", 64'(flag), 64'(m_rw));
            checkOutput("rnd_wrn", 64'(Write_Reg_Num), 64'(m_wrn));
            checkOutput("rnd_wd", 64'(WriteData), 64'(m_wd));
            checkOutput("rnd_count", 64'(count), 64'(mq.size()));
            checkOutput("rnd_busy", 64'(busy), 64'(m_busy));
            checkOutput("rnd_err", 64'(err_waw), 64'(m_err));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
